// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial scan controller and its matcher.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_PAT_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_match_core.sv
// Non-overlapping serial pattern matcher; the window history survives word boundaries
// and idle gaps, and is dropped on a hit or an external flush.
module seq_match_core
    import seq_scan_pkg::*;
#(
    parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic flush,
    output logic hit_c,
    output logic match_pulse
);

    localparam int unsigned HIST_W = PAT_LEN - 1;
    localparam int unsigned FILL_W = $clog2(PAT_LEN);

    logic [HIST_W-1:0]  hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [PAT_LEN-1:0] window_c;

    always_comb begin
        window_c = {hist_q, bit_in};
        hit_c    = bit_valid && (fill_q == FILL_W'(HIST_W)) && (window_c == PATTERN);
    end

    // Flush outranks a coincident hit so an abort never emits a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            fill_q      <= '0;
            match_pulse <= 1'b0;
        end else if (flush) begin
            hist_q      <= '0;
            fill_q      <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= hit_c;
            if (hit_c) begin
                hist_q <= '0;
                fill_q <= '0;
            end else if (bit_valid) begin
                hist_q <= window_c[HIST_W-1:0];
                if (fill_q != FILL_W'(HIST_W)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts parallel words, serialises them MSB-first into the pattern matcher,
// counts matches and stops the scan once the programmed match count is reached.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned        WORD_W  = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done_irq
);

    localparam int unsigned BCNT_W    = $clog2(WORD_W);
    localparam int unsigned CNT_EXT_W = CNT_W + 1;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      shreg_q;
    logic [BCNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       thr_q;
    logic                   done_q;

    logic                   hit_c;
    logic                   final_hit_c;
    logic                   last_bit_c;
    logic                   shifting_c;
    logic                   ready_c;
    logic                   accept_c;
    logic                   arm_c;
    logic                   flush_c;
    logic [CNT_EXT_W-1:0]   count_inc_c;

    seq_match_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (shifting_c),
        .bit_in      (shreg_q[WORD_W-1]),
        .flush       (flush_c),
        .hit_c       (hit_c),
        .match_pulse (match_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; threshold compare uses the pre-saturation count.
    always_comb begin
        state_d     = state_q;
        shifting_c  = (state_q == ST_SHIFT);
        last_bit_c  = (bit_cnt_q == '0);
        count_inc_c = {1'b0, count_q} + CNT_EXT_W'(1);
        final_hit_c = hit_c && (thr_q != '0) && (count_inc_c == {1'b0, thr_q});
        ready_c     = (state_q == ST_ARMED) || (shifting_c && last_bit_c && !final_hit_c);
        accept_c    = in_valid && ready_c && !clear;
        arm_c       = start && !clear && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        flush_c     = clear || arm_c;

        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ARMED;
            ST_ARMED: if (in_valid) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (final_hit_c) begin
                    state_d = ST_DONE;
                end else if (last_bit_c) begin
                    state_d = in_valid ? ST_SHIFT : ST_ARMED;
                end
            end
            ST_DONE:  if (start) state_d = ST_ARMED;
            default:  state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // Shift register, bit counter, saturating match counter and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            count_q   <= '0;
            thr_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
                count_q   <= '0;
            end else begin
                if (arm_c) begin
                    thr_q   <= threshold;
                    count_q <= '0;
                end else if (hit_c) begin
                    count_q <= (count_q == '1) ? count_q : count_inc_c[CNT_W-1:0];
                    done_q  <= final_hit_c;
                end

                if (accept_c) begin
                    shreg_q   <= in_data;
                    bit_cnt_q <= BCNT_W'(WORD_W - 1);
                end else if (shifting_c) begin
                    shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                    if (!last_bit_c) begin
                        bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
                    end
                end
            end
        end
    end

    assign in_ready    = ready_c;
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_SHIFT);
    assign match_count = count_q;
    assign done_irq    = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: default instance plus a 2-bit counter instance
// for saturation, both driven from the same stimulus.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] threshold = 8'h00;
    logic [1:0] threshold2 = 2'b00;

    logic       in_ready, match_pulse, busy, done_irq;
    logic [7:0] match_count;
    logic       in_ready2, match_pulse2, busy2, done_irq2;
    logic [1:0] match_count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .threshold   (threshold),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .busy        (busy),
        .done_irq    (done_irq)
    );

    seq_scan_ctrl #(.CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .threshold   (threshold2),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready2),
        .match_pulse (match_pulse2),
        .match_count (match_count2),
        .busy        (busy2),
        .done_irq    (done_irq2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, collecting match_pulse/done_irq histories (latest in bit 0).
    task automatic run_bits(input int n, output logic [15:0] pv, output logic [15:0] dv);
        pv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            step();
            pv = {pv[14:0], match_pulse};
            dv = {dv[14:0], done_irq};
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic arm(input logic [7:0] thr);
        threshold = thr;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({in_ready, match_pulse, busy, done_irq} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {in_ready, match_pulse, busy, done_irq}); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", match_count); end
        rst_n = 1'b1;
        step();
        total++; if ({in_ready, busy, in_ready2, busy2} !== 4'b0000) begin bad++; $display("FAIL reset_idle got=%b exp=0000", {in_ready, busy, in_ready2, busy2}); end
    endtask

    task automatic test_basic();
        logic [15:0] pv, dv;
        arm(8'd2);
        total++; if ({busy, in_ready} !== 2'b11) begin bad++; $display("FAIL basic_armed got=%b exp=11", {busy, in_ready}); end
        send_word(8'b1101_1101);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_shift got=%b exp=0", in_ready); end
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0001_0001) begin bad++; $display("FAIL basic_pulses got=%b exp=00010001", pv[7:0]); end
        total++; if (dv[7:0] !== 8'b0000_0001) begin bad++; $display("FAIL basic_done got=%b exp=00000001", dv[7:0]); end
        total++; if (match_count !== 8'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", match_count); end
        total++; if ({busy, in_ready} !== 2'b00) begin bad++; $display("FAIL basic_done_state got=%b exp=00", {busy, in_ready}); end
        step();
        total++; if ({done_irq, match_pulse} !== 2'b00 || match_count !== 8'd2) begin bad++; $display("FAIL basic_hold got=%b/%0d exp=00/2", {done_irq, match_pulse}, match_count); end
    endtask

    task automatic test_non_overlap();
        logic [15:0] pv, dv, pv2, dv2, pv3, dv3;
        arm(8'd0);
        total++; if (match_count !== 8'd0 || busy !== 1'b1) begin bad++; $display("FAIL novl_rearm got=%0d/%b exp=0/1", match_count, busy); end
        send_word(8'b1101_1010);
        run_bits(4, pv, dv);
        threshold = 8'd1;
        start     = 1'b1;
        run_bits(1, pv2, dv2);
        start     = 1'b0;
        threshold = 8'd0;
        run_bits(3, pv3, dv3);
        total++; if ({pv[3:0], pv2[0], pv3[2:0]} !== 8'b0001_0000) begin bad++; $display("FAIL novl_pulses got=%b exp=00010000", {pv[3:0], pv2[0], pv3[2:0]}); end
        total++; if ({dv[3:0], dv2[0], dv3[2:0]} !== 8'b0) begin bad++; $display("FAIL novl_done got=%b exp=0", {dv[3:0], dv2[0], dv3[2:0]}); end
        total++; if (match_count !== 8'd1) begin bad++; $display("FAIL novl_count got=%0d exp=1", match_count); end
        total++; if ({busy, in_ready} !== 2'b11) begin bad++; $display("FAIL novl_state got=%b exp=11", {busy, in_ready}); end
    endtask

    task automatic test_word_boundary();
        logic [15:0] pv, dv;
        do_clear();
        total++; if ({busy, in_ready} !== 2'b00 || match_count !== 8'd0) begin bad++; $display("FAIL wb_clear got=%b/%0d exp=00/0", {busy, in_ready}, match_count); end
        arm(8'd0);
        send_word(8'b0000_0011);
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0) begin bad++; $display("FAIL wb_first got=%b exp=0", pv[7:0]); end
        send_word(8'b0100_0000);
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0100_0000) begin bad++; $display("FAIL wb_second got=%b exp=01000000", pv[7:0]); end
        total++; if (match_count !== 8'd1) begin bad++; $display("FAIL wb_count got=%0d exp=1", match_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [3];
        int          acc_cyc [3];
        int          n;
        logic        acc;
        logic [15:0] pv, dv;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hFF;
        acc_cyc[0] = -1;
        acc_cyc[1] = -1;
        acc_cyc[2] = -1;
        do_clear();
        arm(8'd0);
        n        = 0;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c < 30; c++) begin
            acc = in_valid && in_ready;
            step();
            if (acc && n < 3) begin
                acc_cyc[n] = c;
                n++;
                if (n == 3) in_valid = 1'b0;
                else        in_data  = words[n];
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
        total++; if (acc_cyc[0] !== 0 || acc_cyc[1] !== 8 || acc_cyc[2] !== 16) begin bad++; $display("FAIL b2b_cycles got=%0d,%0d,%0d exp=0,8,16", acc_cyc[0], acc_cyc[1], acc_cyc[2]); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL b2b_count got=%0d exp=0", match_count); end

        // Early termination with a follow-on word already offered.
        do_clear();
        arm(8'd1);
        in_valid = 1'b1;
        in_data  = 8'b1101_1111;
        step();
        in_data  = 8'b1101_1101;
        run_bits(4, pv, dv);
        total++; if (pv[3:0] !== 4'b0001 || dv[3:0] !== 4'b0001) begin bad++; $display("FAIL early_pulse got=%b/%b exp=0001/0001", pv[3:0], dv[3:0]); end
        total++; if ({busy, in_ready} !== 2'b00 || match_count !== 8'd1) begin bad++; $display("FAIL early_done got=%b/%0d exp=00/1", {busy, in_ready}, match_count); end
        run_bits(8, pv, dv);
        in_valid = 1'b0;
        total++; if (pv[7:0] !== 8'b0 || dv[7:0] !== 8'b0 || busy !== 1'b0 || match_count !== 8'd1) begin bad++; $display("FAIL early_hold got=%b/%b/%b/%0d exp=0/0/0/1", pv[7:0], dv[7:0], busy, match_count); end
    endtask

    task automatic test_clear_reset();
        logic [15:0] pv, dv;
        arm(8'd0);
        send_word(8'b0000_1101);
        run_bits(3, pv, dv);
        do_clear();
        total++; if ({busy, in_ready, match_pulse} !== 3'b000 || match_count !== 8'd0) begin bad++; $display("FAIL clr_state got=%b/%0d exp=000/0", {busy, in_ready, match_pulse}, match_count); end
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0 || busy !== 1'b0) begin bad++; $display("FAIL clr_quiet got=%b/%b exp=0/0", pv[7:0], busy); end

        // Accept and clear in the same cycle drops the word.
        arm(8'd0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'b1101_1101;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0 || busy !== 1'b0 || match_count !== 8'd0) begin bad++; $display("FAIL clr_accept got=%b/%b/%0d exp=0/0/0", pv[7:0], busy, match_count); end

        // Asynchronous reset mid-word while a pulse is showing.
        arm(8'd0);
        send_word(8'b1101_1101);
        run_bits(4, pv, dv);
        total++; if (match_pulse !== 1'b1 || match_count !== 8'd1) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=1/1", match_pulse, match_count); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({in_ready, match_pulse, busy, done_irq} !== 4'b0000 || match_count !== 8'd0) begin bad++; $display("FAIL rst_async got=%b/%0d exp=0000/0", {in_ready, match_pulse, busy, done_irq}, match_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_bits(8, pv, dv);
        total++; if (pv[7:0] !== 8'b0 || busy !== 1'b0 || match_count !== 8'd0) begin bad++; $display("FAIL rst_after got=%b/%b/%0d exp=0/0/0", pv[7:0], busy, match_count); end
    endtask

    task automatic test_saturation();
        logic [15:0] pv, dv;
        logic [1:0]  exp_cnt [4];
        logic        dones2;
        exp_cnt[0] = 2'd2;
        exp_cnt[1] = 2'd3;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3;
        dones2     = 1'b0;
        do_clear();
        threshold2 = 2'd0;
        arm(8'd0);
        for (int w = 0; w < 4; w++) begin
            send_word(8'b1101_1101);
            for (int b = 0; b < 8; b++) begin
                step();
                dones2 = dones2 | done_irq2;
            end
            total++; if (match_count2 !== exp_cnt[w]) begin bad++; $display("FAIL sat_count_w%0d got=%0d exp=%0d", w, match_count2, exp_cnt[w]); end
        end
        total++; if (dones2 !== 1'b0) begin bad++; $display("FAIL sat_done got=%b exp=0", dones2); end
        total++; if (match_count !== 8'd8) begin bad++; $display("FAIL sat_wide_count got=%0d exp=8", match_count); end
        run_bits(1, pv, dv);
        total++; if (busy2 !== 1'b1 || in_ready2 !== 1'b1) begin bad++; $display("FAIL sat_state got=%b%b exp=11", busy2, in_ready2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_non_overlap();
        test_word_boundary();
        test_back_to_back();
        test_clear_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
